// File: rtl/l1_mem_arbiter_pkg.sv
// Shared CPU parameters for the L1 memory arbiter: FSM states, line geometry
// defaults and data-side access size encodings.
package l1_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IC_FILL,
        ST_DC_ACC,
        ST_RESP
    } arb_state_t;

    localparam int unsigned DEF_RSZ    = 32;
    localparam int unsigned DEF_CL_LEN = 32;
    localparam int unsigned BEATS      = DEF_CL_LEN * 8 / DEF_RSZ;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // Unsupported sizes and misaligned halfword/word accesses are rejected.
    function automatic logic access_fault(input logic [2:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/l1_mem_arbiter_lane_align.sv
// Byte-lane steering for stores and right-justify/extend for loads on a
// 32-bit memory word; purely combinational.
module l1_lane_align
    import l1_mem_arbiter_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  be,
    output logic [31:0] wr_lane,
    output logic [31:0] ld_data,
    output logic        fault
);

    logic [4:0]  shamt;
    logic [31:0] rd_shift;

    always_comb begin
        shamt    = {offset, 3'b000};
        wr_lane  = wr_data << shamt;
        rd_shift = rd_data >> shamt;
        fault    = access_fault(size, offset);
        be       = '0;
        ld_data  = '0;
        case (size)
            SZ_B: begin
                be      = 4'b0001 << offset;
                ld_data = zero_ext ? {24'h0, rd_shift[7:0]}
                                   : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_H: begin
                be      = 4'b0011 << offset;
                ld_data = zero_ext ? {16'h0, rd_shift[15:0]}
                                   : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            SZ_W: begin
                be      = 4'hF;
                ld_data = rd_shift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Arbitrates I-cache line fills and D-side loads/stores onto one 32-bit
// memory port; round-robin on ties, all outputs registered.
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int PC_SZ  = 32,
    parameter int RSZ    = 32,
    parameter int CL_LEN = 32
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                ic_req,
    input  logic [PC_SZ-1:0]    ic_addr,
    output logic                ic_ack,
    output logic [CL_LEN*8-1:0] ic_ack_data,
    input  logic                dc_req,
    input  logic                dc_rw,
    input  logic [PC_SZ-1:0]    dc_rw_addr,
    input  logic [RSZ-1:0]      dc_wr_data,
    input  logic [2:0]          dc_size,
    input  logic                dc_zero_ext,
    output logic                dc_ack,
    output logic                dc_ack_fault,
    output logic [RSZ-1:0]      dc_ack_data,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [PC_SZ-1:0]    mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_be,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata
);

    localparam int NBEATS = CL_LEN * 8 / RSZ;
    localparam int BW     = $clog2(NBEATS);
    localparam int OFF_W  = $clog2(CL_LEN);

    arb_state_t state, state_nxt;

    logic [BW-1:0]          beat;
    logic [BW-1:0]          beat_nxt;
    logic [PC_SZ-OFF_W-1:0] line_base;
    logic                   tie_last_d;
    logic                   grant_ic, grant_dc, last_beat;

    logic       d_rw, d_zext;
    logic [1:0] d_off;
    logic [2:0] d_size;

    logic [1:0]  al_off;
    logic [2:0]  al_size;
    logic        al_zext, al_fault;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ldata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^ic_addr[OFF_W-1:0];

    // Steering sees the live request while granting, then the latched copy.
    always_comb begin
        al_off  = d_off;
        al_size = d_size;
        al_zext = d_zext;
        if (state == ST_IDLE) begin
            al_off  = dc_rw_addr[1:0];
            al_size = dc_size;
            al_zext = dc_zero_ext;
        end
    end

    l1_lane_align u_lane_align (
        .offset   (al_off),
        .size     (al_size),
        .zero_ext (al_zext),
        .wr_data  (dc_wr_data),
        .rd_data  (mem_rdata),
        .be       (al_be),
        .wr_lane  (al_wdata),
        .ld_data  (al_ldata),
        .fault    (al_fault)
    );

    // The tie pointer only moves on contested grants, so a lone request never
    // steals the next tie from the other side.
    always_comb begin
        state_nxt = state;
        grant_ic  = 1'b0;
        grant_dc  = 1'b0;
        beat_nxt  = beat + 1'b1;
        last_beat = (beat == BW'(NBEATS - 1));
        case (state)
            ST_IDLE: begin
                if (ic_req && (!dc_req || tie_last_d)) begin
                    grant_ic = 1'b1;
                end else if (dc_req) begin
                    grant_dc = 1'b1;
                end
                if (grant_ic) begin
                    state_nxt = ST_IC_FILL;
                end else if (grant_dc) begin
                    state_nxt = al_fault ? ST_RESP : ST_DC_ACC;
                end
            end
            ST_IC_FILL: if (mem_ack && last_beat) state_nxt = ST_RESP;
            ST_DC_ACC:  if (mem_ack) state_nxt = ST_RESP;
            ST_RESP:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            beat         <= '0;
            line_base    <= '0;
            tie_last_d   <= 1'b1;
            d_rw         <= 1'b0;
            d_zext       <= 1'b0;
            d_off        <= '0;
            d_size       <= '0;
            ic_ack       <= 1'b0;
            ic_ack_data  <= '0;
            dc_ack       <= 1'b0;
            dc_ack_fault <= 1'b0;
            dc_ack_data  <= '0;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
        end else begin
            ic_ack       <= 1'b0;
            dc_ack       <= 1'b0;
            dc_ack_fault <= 1'b0;
            dc_ack_data  <= '0;
            case (state)
                ST_IDLE: begin
                    if (ic_req && dc_req) tie_last_d <= grant_dc;
                    if (grant_ic) begin
                        line_base <= ic_addr[PC_SZ-1:OFF_W];
                        beat      <= '0;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_be    <= 4'hF;
                        mem_wdata <= '0;
                        mem_addr  <= {ic_addr[PC_SZ-1:OFF_W], {OFF_W{1'b0}}};
                    end else if (grant_dc) begin
                        d_rw   <= dc_rw;
                        d_zext <= dc_zero_ext;
                        d_off  <= dc_rw_addr[1:0];
                        d_size <= dc_size;
                        if (al_fault) begin
                            dc_ack       <= 1'b1;
                            dc_ack_fault <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_wr    <= ~dc_rw;
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                            mem_addr  <= {dc_rw_addr[PC_SZ-1:2], 2'b00};
                        end
                    end
                end
                ST_IC_FILL: begin
                    if (mem_ack) begin
                        ic_ack_data[32*beat +: 32] <= mem_rdata;
                        beat     <= beat_nxt;
                        mem_addr <= {line_base, beat_nxt, 2'b00};
                        if (last_beat) begin
                            ic_ack   <= 1'b1;
                            mem_req  <= 1'b0;
                            mem_be   <= '0;
                            mem_addr <= '0;
                        end
                    end
                end
                ST_DC_ACC: begin
                    if (mem_ack) begin
                        dc_ack      <= 1'b1;
                        dc_ack_data <= d_rw ? al_ldata : '0;
                        mem_req     <= 1'b0;
                        mem_wr      <= 1'b0;
                        mem_be      <= '0;
                        mem_wdata   <= '0;
                        mem_addr    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized self-checking bench for l1_mem_arbiter against a byte-level
// reference memory and a simple round-robin tie model.
module tb_l1_mem_arbiter;
    import l1_mem_arbiter_pkg::*;

    localparam int PC_SZ  = 32;
    localparam int RSZ    = 32;
    localparam int CL_LEN = 32;
    localparam int NB     = CL_LEN * 8 / RSZ;

    logic                clk_in = 1'b0;
    logic                reset_in = 1'b0;
    logic                ic_req = 1'b0;
    logic [PC_SZ-1:0]    ic_addr = '0;
    logic                ic_ack;
    logic [CL_LEN*8-1:0] ic_ack_data;
    logic                dc_req = 1'b0, dc_rw = 1'b0, dc_zero_ext = 1'b0;
    logic [PC_SZ-1:0]    dc_rw_addr = '0;
    logic [RSZ-1:0]      dc_wr_data = '0;
    logic [2:0]          dc_size = '0;
    logic                dc_ack, dc_ack_fault;
    logic [RSZ-1:0]      dc_ack_data;
    logic                mem_req, mem_wr;
    logic [PC_SZ-1:0]    mem_addr;
    logic [31:0]         mem_wdata;
    logic [3:0]          mem_be;
    logic                mem_ack = 1'b0;
    logic [31:0]         mem_rdata = '0;

    l1_mem_arbiter #(.PC_SZ(PC_SZ), .RSZ(RSZ), .CL_LEN(CL_LEN)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_ack_data(ic_ack_data),
        .dc_req(dc_req), .dc_rw(dc_rw), .dc_rw_addr(dc_rw_addr), .dc_wr_data(dc_wr_data),
        .dc_size(dc_size), .dc_zero_ext(dc_zero_ext), .dc_ack(dc_ack),
        .dc_ack_fault(dc_ack_fault), .dc_ack_data(dc_ack_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Memory responder: rmode 0 = memory array, 1 = rdata equals address, 2 = fixed word.
    int          rmode = 0;
    int          ack_pct = 100;
    logic [31:0] fixed_rdata = '0;
    logic [31:0] mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;
    beat_t log_q[$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (rmode == 1) return a;
        if (rmode == 2) return fixed_rdata;
        if (mem.exists(a >> 2)) return mem[a >> 2];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
        return init_word(a);
    endfunction

    initial begin
        forever begin
            @(negedge clk_in);
            if (!reset_in) begin
                mem_ack = 1'b0;
            end else if (mem_req && $urandom_range(99) < ack_pct) begin
                automatic beat_t b;
                automatic logic [31:0] w;
                b.wr = mem_wr; b.addr = mem_addr; b.be = mem_be; b.wdata = mem_wdata;
                log_q.push_back(b);
                mem_ack   = 1'b1;
                mem_rdata = mem_wr ? 32'hDEAD_BEEF : mem_rd(mem_addr);
                if (mem_wr) begin
                    w = (mem.exists(mem_addr >> 2)) ? mem[mem_addr >> 2] : init_word(mem_addr);
                    for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                    mem[mem_addr >> 2] = w;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Spec-level expectations built one byte at a time.
    function automatic logic [31:0] exp_load(input logic [31:0] w, input int off, input int size,
                                             input logic zext);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (!zext && size < 4 && v[8*size-1])
            for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input int off, input int size);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < size; i++) m[off+i] = 1'b1;
        return m;
    endfunction

    function automatic bit exp_fault(input int off, input int size);
        if (size == 1) return 0;
        if (size == 2) return (off % 2) != 0;
        if (size == 4) return off != 0;
        return 1;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input int size, input logic [31:0] wdata);
        logic [31:0] w;
        w = ref_rd(addr);
        for (int i = 0; i < size; i++) w[8*(addr[1:0]+i) +: 8] = wdata[8*i +: 8];
        ref_mem[addr >> 2] = w;
    endtask

    task automatic apply_reset();
        reset_in = 1'b0;
        ic_req = 1'b0;
        dc_req = 1'b0;
        repeat (3) @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    task automatic ic_txn(input logic [31:0] addr, output logic [CL_LEN*8-1:0] line,
                          output int cycles, output bit ok);
        @(negedge clk_in);
        ic_req = 1'b1;
        ic_addr = addr;
        ok = 0; cycles = 0; line = '0;
        while (!ok && cycles < 400) begin
            @(negedge clk_in);
            cycles++;
            if (ic_ack === 1'b1) begin ok = 1; line = ic_ack_data; end
        end
        ic_req = 1'b0;
    endtask

    task automatic dc_txn(input logic rw, input logic [31:0] addr, input logic [2:0] size,
                          input logic zext, input logic [31:0] wdata, output logic [31:0] data,
                          output logic fault, output int cycles, output bit ok);
        @(negedge clk_in);
        dc_req = 1'b1; dc_rw = rw; dc_rw_addr = addr; dc_size = size;
        dc_zero_ext = zext; dc_wr_data = wdata;
        ok = 0; cycles = 0; data = 'x; fault = 1'bx;
        while (!ok && cycles < 400) begin
            @(negedge clk_in);
            cycles++;
            if (dc_ack === 1'b1) begin ok = 1; data = dc_ack_data; fault = dc_ack_fault; end
        end
        dc_req = 1'b0;
        dc_rw_addr = $urandom;
        dc_wr_data = $urandom;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({mem_req, mem_wr, ic_ack, dc_ack, dc_ack_fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_wr, ic_ack, dc_ack, dc_ack_fault});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be, dc_ack_data} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h be=%h dcdata=%h want 0", mem_addr, mem_wdata, mem_be, dc_ack_data);
        end
        checks++;
        if (ic_ack_data !== '0) begin
            errors++;
            $display("FAIL reset_line got %h want 0", ic_ack_data);
        end
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got %b want 0", mem_req);
        end
    endtask

    task automatic test_ic_fill();
        logic [CL_LEN*8-1:0] line;
        int cyc;
        bit ok;
        rmode = 1; ack_pct = 100;
        log_q.delete();
        ic_txn(32'h0000_1234, line, cyc, ok);
        checks++;
        if (!ok || cyc != NB + 1) begin
            errors++;
            $display("FAIL fill_latency got ok=%0d cycles=%0d want cycles=%0d", ok, cyc, NB + 1);
        end
        checks++;
        if (log_q.size() != NB) begin
            errors++;
            $display("FAIL fill_beats got %0d want %0d", log_q.size(), NB);
        end
        for (int k = 0; k < NB && k < log_q.size(); k++) begin
            checks++;
            if (log_q[k].addr !== 32'h1220 + 4*k || log_q[k].wr !== 1'b0 || log_q[k].be !== 4'hF) begin
                errors++;
                $display("FAIL fill_addr[%0d] got addr=%h wr=%b be=%h want addr=%h wr=0 be=f",
                         k, log_q[k].addr, log_q[k].wr, log_q[k].be, 32'h1220 + 4*k);
            end
            checks++;
            if (line[32*k +: 32] !== 32'h1220 + 4*k) begin
                errors++;
                $display("FAIL fill_slot[%0d] got %h want %h", k, line[32*k +: 32], 32'h1220 + 4*k);
            end
        end
        @(negedge clk_in);
        checks++;
        if (ic_ack !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fill_pulse got ic_ack=%b mem_req=%b want 0 0", ic_ack, mem_req);
        end
        repeat (3) @(negedge clk_in);
        checks++;
        if (ic_ack_data !== line) begin
            errors++;
            $display("FAIL fill_hold got %h want %h", ic_ack_data, line);
        end
    endtask

    task automatic test_arbitration();
        logic [CL_LEN*8-1:0] line;
        logic [31:0] data;
        logic fault;
        int icc, dcc;
        bit iok, dok;
        apply_reset();
        rmode = 0; ack_pct = 100;
        fork
            ic_txn(32'h0000_0500, line, icc, iok);
            dc_txn(1'b1, 32'h0000_0510, SZ_W, 1'b0, '0, data, fault, dcc, dok);
        join
        checks++;
        if (!iok || !dok || icc >= dcc) begin
            errors++;
            $display("FAIL tie1_order got ic=%0d dc=%0d (ok %0d %0d) want ic first", icc, dcc, iok, dok);
        end
        checks++;
        if (data !== ref_rd(32'h510) || fault !== 1'b0) begin
            errors++;
            $display("FAIL tie1_dc_data got %h f=%b want %h f=0", data, fault, ref_rd(32'h510));
        end
        checks++;
        if (line[32*3 +: 32] !== ref_rd(32'h50C)) begin
            errors++;
            $display("FAIL tie1_line got %h want %h", line[32*3 +: 32], ref_rd(32'h50C));
        end
        fork
            ic_txn(32'h0000_0520, line, icc, iok);
            dc_txn(1'b1, 32'h0000_0532, SZ_H, 1'b1, '0, data, fault, dcc, dok);
        join
        checks++;
        if (!iok || !dok || dcc >= icc || dcc != 2) begin
            errors++;
            $display("FAIL tie2_order got ic=%0d dc=%0d (ok %0d %0d) want dc first at 2", icc, dcc, iok, dok);
        end
        checks++;
        if (data !== exp_load(ref_rd(32'h530), 2, 2, 1'b1)) begin
            errors++;
            $display("FAIL tie2_dc_data got %h want %h", data, exp_load(ref_rd(32'h530), 2, 2, 1'b1));
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] data;
        logic fault;
        int cyc;
        bit ok;
        rmode = 2; fixed_rdata = 32'h80FF_FFFF; ack_pct = 100;
        log_q.delete();
        dc_txn(1'b1, 32'h0000_0103, SZ_B, 1'b0, '0, data, fault, cyc, ok);
        checks++;
        if (!ok || data !== 32'hFFFF_FF80 || fault !== 1'b0) begin
            errors++;
            $display("FAIL load_sext got %h f=%b ok=%0d want ffffff80", data, fault, ok);
        end
        checks++;
        if (log_q.size() != 1 || log_q[0].addr !== 32'h100 || log_q[0].wr !== 1'b0) begin
            errors++;
            $display("FAIL load_beat got n=%0d want one read at 00000100", log_q.size());
        end
        dc_txn(1'b1, 32'h0000_0103, SZ_B, 1'b1, '0, data, fault, cyc, ok);
        checks++;
        if (!ok || data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL load_zext got %h ok=%0d want 00000080", data, ok);
        end
        rmode = 0;
    endtask

    task automatic test_store_half();
        logic [31:0] data;
        logic fault;
        int cyc;
        bit ok;
        rmode = 0; ack_pct = 100;
        log_q.delete();
        dc_txn(1'b0, 32'h0000_0202, SZ_H, 1'b0, 32'h0000_ABCD, data, fault, cyc, ok);
        ref_store(32'h202, 2, 32'h0000_ABCD);
        checks++;
        if (log_q.size() != 1) begin
            errors++;
            $display("FAIL store_beats got %0d want 1", log_q.size());
        end else begin
            checks++;
            if (log_q[0].addr !== 32'h200 || log_q[0].be !== 4'b1100 ||
                log_q[0].wdata !== 32'hABCD_0000 || log_q[0].wr !== 1'b1) begin
                errors++;
                $display("FAIL store_half got addr=%h be=%b wdata=%h wr=%b want 200 1100 abcd0000 1",
                         log_q[0].addr, log_q[0].be, log_q[0].wdata, log_q[0].wr);
            end
        end
        checks++;
        if (!ok || data !== '0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL store_ack got data=%h f=%b ok=%0d want 0 0", data, fault, ok);
        end
    endtask

    task automatic test_fault();
        logic [31:0] data;
        logic fault;
        int cyc;
        bit ok;
        int sz_tab[4]  = '{4, 2, 3, 0};
        int adr_tab[4] = '{32'h201, 32'h203, 32'h200, 32'h204};
        ack_pct = 100;
        for (int t = 0; t < 4; t++) begin
            log_q.delete();
            dc_txn(t[0], adr_tab[t], 3'(sz_tab[t]), 1'b0, 32'h1234_5678, data, fault, cyc, ok);
            checks++;
            if (!ok || cyc != 1 || fault !== 1'b1 || data !== '0 || log_q.size() != 0) begin
                errors++;
                $display("FAIL fault[%0d] got ok=%0d cyc=%0d f=%b data=%h beats=%0d want 1 1 1 0 0",
                         t, ok, cyc, fault, data, log_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [CL_LEN*8-1:0] line;
        int cyc, n;
        bit ok, spurious;
        rmode = 1; ack_pct = 100;
        log_q.delete();
        @(negedge clk_in);
        ic_req = 1'b1; ic_addr = 32'h0000_4000;
        n = 0;
        while (log_q.size() < 3 && n < 100) begin @(negedge clk_in); n++; end
        @(posedge clk_in);
        #2 reset_in = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_wr, ic_ack, dc_ack, dc_ack_fault, mem_addr, mem_be, mem_wdata, dc_ack_data} !== '0
            || ic_ack_data !== '0) begin
            errors++;
            $display("FAIL midfill_reset got req=%b addr=%h line=%h want all 0", mem_req, mem_addr, ic_ack_data);
        end
        ic_req = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
        spurious = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (ic_ack !== 1'b0 || dc_ack !== 1'b0 || mem_req !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL midfill_spurious got activity after release want none");
        end
        rmode = 0;
        ic_txn(32'h0000_4000, line, cyc, ok);
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (!ok || line[32*k +: 32] !== ref_rd(32'h4000 + 4*k)) begin
                errors++;
                $display("FAIL refill_slot[%0d] got %h want %h", k, line[32*k +: 32], ref_rd(32'h4000 + 4*k));
            end
        end
    endtask

    task automatic test_random();
        logic [CL_LEN*8-1:0] line;
        logic [31:0] data, addr, wdata, w;
        logic fault, rw, zext;
        int cyc, size, off;
        bit ok, efault;
        int sz_tab[10] = '{1, 2, 4, 1, 2, 4, 3, 0, 5, 7};
        rmode = 0;
        for (int t = 0; t < 40; t++) begin
            ack_pct = $urandom_range(100, 30);
            log_q.delete();
            if ($urandom_range(3) == 0) begin
                addr = 32'h300 + 32'($urandom_range(63));
                ic_txn(addr, line, cyc, ok);
                checks++;
                if (!ok || log_q.size() != NB) begin
                    errors++;
                    $display("FAIL rnd_fill[%0d] got ok=%0d beats=%0d want %0d", t, ok, log_q.size(), NB);
                end
                for (int k = 0; k < NB; k++) begin
                    checks++;
                    if (line[32*k +: 32] !== ref_rd({addr[31:5], 5'b0} + 4*k)) begin
                        errors++;
                        $display("FAIL rnd_slot[%0d.%0d] got %h want %h", t, k, line[32*k +: 32],
                                 ref_rd({addr[31:5], 5'b0} + 4*k));
                    end
                end
            end else begin
                size = sz_tab[$urandom_range(9)];
                off  = $urandom_range(3);
                if ($urandom_range(3) != 0) off = (size == 4) ? 0 : (size == 2) ? (off & 2) : off;
                addr  = 32'h300 + 4 * 32'($urandom_range(15)) + 32'(off);
                rw    = 1'($urandom_range(1));
                zext  = 1'($urandom_range(1));
                wdata = $urandom;
                if (size < 4) wdata = wdata & ((32'h1 << (8*size)) - 1);
                efault = exp_fault(off, size);
                w = ref_rd(addr);
                dc_txn(rw, addr, 3'(size), zext, wdata, data, fault, cyc, ok);
                checks++;
                if (!ok || fault !== efault ||
                    data !== ((rw && !efault) ? exp_load(w, off, size, zext) : 32'h0)) begin
                    errors++;
                    $display("FAIL rnd_dc[%0d] rw=%b a=%h sz=%0d got ok=%0d f=%b d=%h want f=%b d=%h",
                             t, rw, addr, size, ok, fault, data, efault,
                             (rw && !efault) ? exp_load(w, off, size, zext) : 32'h0);
                end
                checks++;
                if (log_q.size() != (efault ? 0 : 1)) begin
                    errors++;
                    $display("FAIL rnd_beats[%0d] got %0d want %0d", t, log_q.size(), efault ? 0 : 1);
                end else if (!efault) begin
                    checks++;
                    if (log_q[0].addr !== {addr[31:2], 2'b00} || log_q[0].wr !== !rw ||
                        (!rw && (log_q[0].be !== exp_be(off, size) ||
                                 log_q[0].wdata !== (wdata << (8*off))))) begin
                        errors++;
                        $display("FAIL rnd_bus[%0d] got a=%h wr=%b be=%b wd=%h want a=%h wr=%b be=%b wd=%h",
                                 t, log_q[0].addr, log_q[0].wr, log_q[0].be, log_q[0].wdata,
                                 {addr[31:2], 2'b00}, !rw, exp_be(off, size), wdata << (8*off));
                    end
                    if (!rw) ref_store(addr, size, wdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ic_fill();
        test_arbitration();
        test_load_ext();
        test_store_half();
        test_fault();
        test_reset_mid_fill();
        test_random();
        repeat (2) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
